// File: rtl/fg_pkg.sv
// Shared types for the self-test delay stage and the shutter gate pulse generator.
package fg_pkg;

    localparam int FG_CNT_W  = 32;
    localparam int FG_MISS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GATE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } fg_state_t;

endpackage : fg_pkg

// File: rtl/fg_gate_pulse.sv
// Shutter gate pulse generator: a trigger starts a fixed-width gate followed by a dead time.
// The block tracks how many pulses were started and how many triggers were dropped while it was busy.
module fg_gate_pulse
    import fg_pkg::*;
#(
    parameter int CNT_W  = FG_CNT_W,
    parameter int MISS_W = FG_MISS_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              trig,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  holdoff,
    input  logic              clear,
    output logic              gate_out,
    output logic              busy,
    output logic [CNT_W-1:0]  pulse_count,
    output logic [MISS_W-1:0] missed_count,
    output logic              overrun
);

    fg_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  holdoff_reg, holdoff_next;
    logic              gate_reg, gate_next;
    logic [CNT_W-1:0]  pulse_reg;
    logic [MISS_W-1:0] missed_reg;
    logic              overrun_reg;
    logic              accept;
    logic              miss;

    // The down-counter is loaded with the gate length at trigger time, so it doubles
    // as the latched width; only holdoff needs its own capture register.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        holdoff_next = holdoff_reg;
        accept       = 1'b0;
        miss         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable && trig) begin
                    accept       = 1'b1;
                    state_next   = ST_GATE;
                    cnt_next     = (width == '0) ? '0 : width - CNT_W'(1);
                    holdoff_next = holdoff;
                end
            end
            ST_GATE: begin
                miss = enable && trig;
                if (cnt_reg == '0) begin
                    if (holdoff_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_HOLDOFF;
                        cnt_next   = holdoff_reg - CNT_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                miss = enable && trig;
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        gate_next = (state_next == ST_GATE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            holdoff_reg <= '0;
            gate_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            holdoff_reg <= holdoff_next;
            gate_reg    <= gate_next;
        end
    end

    // Clear wins over a dropped trigger, but a same-cycle accepted trigger still counts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pulse_reg   <= '0;
            missed_reg  <= '0;
            overrun_reg <= 1'b0;
        end else if (clear) begin
            pulse_reg   <= accept ? CNT_W'(1) : '0;
            missed_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (accept) begin
                pulse_reg <= pulse_reg + CNT_W'(1);
            end
            if (miss) begin
                overrun_reg <= 1'b1;
                if (missed_reg != '1) begin
                    missed_reg <= missed_reg + MISS_W'(1);
                end
            end
        end
    end

    assign gate_out     = gate_reg;
    assign busy         = (state_reg == ST_GATE) || (state_reg == ST_HOLDOFF);
    assign pulse_count  = pulse_reg;
    assign missed_count = missed_reg;
    assign overrun      = overrun_reg;

endmodule : fg_gate_pulse

// File: tb/tb_fg_gate_pulse.sv
// Bench for fg_gate_pulse: directed scenarios plus random traffic, checked every cycle against
// a timeline model (gate/busy windows expressed as absolute cycle ranges).
module tb_fg_gate_pulse;

    localparam int CNT_W  = 8;
    localparam int MISS_W = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              trig;
    logic [CNT_W-1:0]  width;
    logic [CNT_W-1:0]  holdoff;
    logic              clear;
    logic              gate_out;
    logic              busy;
    logic [CNT_W-1:0]  pulse_count;
    logic [MISS_W-1:0] missed_count;
    logic              overrun;

    fg_gate_pulse #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .trig         (trig),
        .width        (width),
        .holdoff      (holdoff),
        .clear        (clear),
        .gate_out     (gate_out),
        .busy         (busy),
        .pulse_count  (pulse_count),
        .missed_count (missed_count),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model: the cycle index at which the pulse starts, ends, and the dead time ends.
    int cyc        = 0;
    int gate_start = 1;
    int gate_end   = 0;
    int busy_end   = 0;
    int m_pulse    = 0;
    int m_missed   = 0;
    int m_ovr      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit model_busy(input int t);
        return (t >= gate_start) && (t <= busy_end);
    endfunction

    function automatic bit model_gate(input int t);
        return (t >= gate_start) && (t <= gate_end);
    endfunction

    task automatic model_reset();
        gate_start = 1;
        gate_end   = 0;
        busy_end   = 0;
        m_pulse    = 0;
        m_missed   = 0;
        m_ovr      = 0;
    endtask

    // Check the current cycle's outputs, apply inputs for this cycle, advance the model and the clock.
    task automatic step(input bit en, input bit tr, input int w, input int h, input bit clr);
        bit acc;
        bit ms;
        check("gate_out", 32'(gate_out), 32'(model_gate(cyc)));
        check("busy", 32'(busy), 32'(model_busy(cyc)));
        check("pulse_count", 32'(pulse_count), 32'(m_pulse));
        check("missed_count", 32'(missed_count), 32'(m_missed));
        check("overrun", 32'(overrun), 32'(m_ovr));
        enable  = en;
        trig    = tr;
        width   = CNT_W'(w);
        holdoff = CNT_W'(h);
        clear   = clr;
        acc = en && tr && !model_busy(cyc);
        ms  = en && tr && model_busy(cyc);
        if (acc) begin
            gate_start = cyc + 1;
            gate_end   = cyc + ((w == 0) ? 1 : w);
            busy_end   = gate_end + h;
            $display("pulse accepted at cycle %0d: width %0d holdoff %0d", cyc, w, h);
        end
        if (clr) begin
            m_pulse  = acc ? 1 : 0;
            m_missed = 0;
            m_ovr    = 0;
        end else begin
            m_pulse = (m_pulse + (acc ? 1 : 0)) % (1 << CNT_W);
            if (ms) begin
                m_ovr    = 1;
                m_missed = (m_missed + 1 > (1 << MISS_W) - 1) ? (1 << MISS_W) - 1 : m_missed + 1;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    // Idle cycles with wandering width/holdoff inputs, which must not disturb a pulse in flight.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 1'b0);
        end
    endtask

    // Reset asserted between clock edges: outputs must clear before any edge arrives.
    task automatic async_reset();
        #1 reset_n = 1'b0;
        #1;
        check("rst_gate_out", 32'(gate_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulse_count", 32'(pulse_count), 32'd0);
        check("rst_missed_count", 32'(missed_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        model_reset();
        #1 reset_n = 1'b1;
        $display("async reset applied at cycle %0d", cyc);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        trig    = 1'b0;
        width   = '0;
        holdoff = '0;
        clear   = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_gate_out", 32'(gate_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pulse_count", 32'(pulse_count), 32'd0);
        reset_n = 1'b1;

        // Trigger on the very first edge after reset release.
        step(1'b1, 1'b1, 2, 1, 1'b0);
        idle(6);

        // Basic pulse width 5, holdoff 3.
        step(1'b1, 1'b1, 5, 3, 1'b0);
        idle(10);

        // Overrun: second trigger lands inside the gate.
        step(1'b1, 1'b1, 4, 4, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 4, 4, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        idle(1);

        // Zero width and holdoff, back-to-back.
        step(1'b1, 1'b1, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b0);
        idle(3);

        // Clear colliding with a missed trigger, then a later miss.
        step(1'b1, 1'b1, 6, 2, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 6, 2, 1'b1);
        idle(1);
        step(1'b1, 1'b1, 6, 2, 1'b0);
        idle(10);

        // Clear together with an accepted trigger.
        step(1'b1, 1'b1, 2, 1, 1'b1);
        idle(5);

        // Async reset in the middle of a width-10 pulse, then a full pulse.
        step(1'b1, 1'b1, 10, 2, 1'b0);
        idle(2);
        async_reset();
        step(1'b1, 1'b1, 10, 2, 1'b0);
        idle(14);

        // Missed-count saturation.
        step(1'b1, 1'b1, 20, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 20, 0, 1'b0);
        idle(16);

        // Triggers with enable low are ignored entirely.
        step(1'b0, 1'b1, 3, 3, 1'b0);
        idle(3);

        // Enable dropped mid-pulse: pulse and holdoff still complete.
        step(1'b1, 1'b1, 4, 2, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1, 1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                 ($urandom_range(0, 39) == 0));
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fg_gate_pulse

// File: doc/fg_gate_pulse.md
FG_GATE_PULSE -- requirements
Module: fg_gate_pulse

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the width/holdoff inputs and the pulse counter.
REQ-002 SHALL have parameter MISS_W, default 16: width of the missed-trigger counter.
REQ-003 SHALL have port clock  input  1  single system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  arms the block; triggers are ignored while low.
REQ-006 SHALL have port trig  input  1  one-cycle strobe from the upstream self-test delay stage, marking delay expiry.
REQ-007 SHALL have port width  input  CNT_W  gate pulse length in clock cycles.
REQ-008 SHALL have port holdoff  input  CNT_W  dead time after the gate, in cycles.
REQ-009 SHALL have port clear  input  1  synchronous clear of the counters and the overrun flag.
REQ-010 SHALL have port gate_out  output  1  shutter gate pulse.
REQ-011 SHALL have port busy  output  1  high in the GATE and HOLDOFF states.
REQ-012 SHALL have port pulse_count  output  CNT_W  number of gate pulses started.
REQ-013 SHALL have port missed_count  output  MISS_W  number of triggers dropped while busy.
REQ-014 SHALL have port overrun  output  1  sticky flag, set by any dropped trigger.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, GATE, HOLDOFF.
REQ-016 SHALL, in IDLE with enable=1 and trig=1 in cycle N:
- latch width and holdoff;
- enter GATE;
- drive gate_out high from cycle N+1.
REQ-017 SHALL hold gate_out high for exactly max(width,1) cycles; width=0 is treated as 1.
REQ-018 SHALL, at the end of GATE, enter HOLDOFF for exactly the latched holdoff cycles; holdoff=0 returns to IDLE directly.
REQ-019 SHALL accept a new trigger in the first cycle IDLE is re-entered (back-to-back operation).
REQ-020 SHALL ignore input changes to width and holdoff during GATE and HOLDOFF; the values latched at trigger apply.
REQ-021 SHALL increment pulse_count on every accepted trigger, wrapping modulo 2^CNT_W.
REQ-022 SHALL, for a trig with enable=1 in GATE or HOLDOFF:
- increment missed_count, saturating at all-ones;
- set overrun.
REQ-023 SHALL ignore trig while enable=0: it is not accepted and not counted as missed.
REQ-024 SHALL let a pulse in progress complete, including holdoff, if enable drops mid-operation.
REQ-025 SHALL, on clear:
- zero pulse_count, missed_count and overrun in the next cycle;
- leave the FSM and gate_out unaffected.
REQ-026 SHALL give clear priority over a same-cycle missed-trigger increment.
REQ-027 SHALL increment pulse_count on a same-cycle clear and accepted trigger, so pulse_count reads 1.
REQ-028 SHALL drive gate_out directly from a register, with no combinational path from trig.
REQ-029 SHALL recover any illegal state to IDLE on the next clock.

Reset
REQ-030 SHALL, on reset_n=0, immediately set:
- state to IDLE;
- gate_out=0 and busy=0;
- pulse_count=0, missed_count=0, overrun=0;
- the latched width/holdoff and the internal down-counter to 0.
REQ-031 SHALL abort a reset asserted mid-pulse, dropping gate_out asynchronously.
REQ-032 SHALL accept a trigger on the first clock edge after reset_n deasserts.

Structure
REQ-033 SHALL take the state enum (IDLE, GATE, HOLDOFF) from the shared package fg_pkg, which the upstream self-test FSM also uses for its state types.
REQ-034 SHALL place the default counter widths as constants in fg_pkg.
REQ-035 SHALL implement the single loadable down-counter shared by GATE and HOLDOFF inline; no sub-module is required.

Verification
REQ-036 Basic pulse: width=5, holdoff=3, trig at cycle 10 -> gate_out high cycles 11-15, busy high cycles 11-18, pulse_count=1.
REQ-037 Overrun: width=4, holdoff=4, trig at cycles 10 and 13 -> one pulse only; missed_count=1; overrun=1.
REQ-038 Zero parameters: width=0, holdoff=0, trig at cycles 10 and 12 -> two 1-cycle pulses at cycles 11 and 13; no misses.
REQ-039 Clear collision: a missed trig coincides with clear -> missed_count=0 and overrun=0 afterwards; a later miss gives missed_count=1.
REQ-040 Async reset: reset_n pulsed low at cycle 13 of a width=10 pulse -> gate_out drops without waiting for a clock, counts read 0, and the next trig produces a full pulse.
REQ-041 Saturation and gating:
- with MISS_W=2, drive 5 missed triggers -> missed_count=3;
- with enable=0, trig -> no pulse and no count change.
